zap_register_file_gen2: RTL and testbench

Parametrised second-generation ZAP register file with a configurable read-port count, one or two write ports, same-cycle write-to-read bypass, and a sequenced exception-entry engine. It sits between the writeback stage and the issue/fetch stages. It owns the physical register array, the PC and the CPSR, and computes the next PC from stall, clear and exception inputs. With one write port, exception entry takes two cycles; the block signals this with `o_busy` so upstream holds writeback.

---
 rtl/zap_register_file_gen2_pkg.sv | 79 +++++++
 rtl/zap_regf_storage.sv | 48 ++++
 rtl/zap_register_file_gen2.sv | 175 +++++++++++++++++
 tb/tb_zap_register_file_gen2.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/zap_register_file_gen2_pkg.sv
// rtl/zap_register_file_gen2_pkg.sv - shared indices, modes, CPSR fields and exception decode
// Purpose: physical register map, mode encodings, CPSR bit positions,
//          exception vectors and the prioritised exception decoder.
// Ports:   none (package).
package zap_register_file_gen2_pkg;

  // Physical register map. Architectural PC is not stored in the array;
  // reads of ARCH_PC are served from the PC register.
  localparam int ARCH_PC          = 15;
  localparam int PHY_FIQ_R14      = 22;  // FIQ banks R8..R14 at 16..22
  localparam int PHY_IRQ_R14      = 24;
  localparam int PHY_SVC_R14      = 26;
  localparam int PHY_UND_R14      = 28;
  localparam int PHY_ABT_R14      = 30;
  localparam int PHY_CPSR         = 31;
  localparam int PHY_FIQ_SPSR     = 32;
  localparam int PHY_IRQ_SPSR     = 33;
  localparam int PHY_SVC_SPSR     = 34;
  localparam int PHY_UND_SPSR     = 35;
  localparam int PHY_ABT_SPSR     = 36;
  localparam int PHY_RAZ_REGISTER = 37;

  localparam logic [4:0] FIQ_MODE = 5'h11;
  localparam logic [4:0] IRQ_MODE = 5'h12;
  localparam logic [4:0] SVC_MODE = 5'h13;
  localparam logic [4:0] ABT_MODE = 5'h17;
  localparam logic [4:0] UND_MODE = 5'h1B;

  localparam int CPSR_T = 5;
  localparam int CPSR_F = 6;
  localparam int CPSR_I = 7;

  localparam logic [31:0] CPSR_RESET = 32'h0000_00D3;  // SVC, I=1, F=1, T=0

  localparam logic [31:0] VEC_UND  = 32'h04;
  localparam logic [31:0] VEC_SWI  = 32'h08;
  localparam logic [31:0] VEC_IABT = 32'h0C;
  localparam logic [31:0] VEC_DABT = 32'h10;
  localparam logic [31:0] VEC_IRQ  = 32'h18;
  localparam logic [31:0] VEC_FIQ  = 32'h1C;

  typedef enum logic {IDLE = 1'b0, SAVE_SPSR = 1'b1} regf_state_t;

  typedef struct packed {
    logic [4:0]  mode;
    logic [31:0] vector;
    logic [7:0]  r14;
    logic [7:0]  spsr;
    logic        fiq;
    logic        irq;
  } exc_info_t;

  // exc = {dabt, fiq, irq, iabt, swi, und}; bit 5 wins.
  function automatic exc_info_t exc_decode(input logic [5:0] exc);
    exc_info_t info;
    info = '0;
    if (exc[5]) begin
      info.mode = ABT_MODE; info.vector = VEC_DABT;
      info.r14 = 8'(PHY_ABT_R14); info.spsr = 8'(PHY_ABT_SPSR);
    end else if (exc[4]) begin
      info.mode = FIQ_MODE; info.vector = VEC_FIQ; info.fiq = 1'b1;
      info.r14 = 8'(PHY_FIQ_R14); info.spsr = 8'(PHY_FIQ_SPSR);
    end else if (exc[3]) begin
      info.mode = IRQ_MODE; info.vector = VEC_IRQ; info.irq = 1'b1;
      info.r14 = 8'(PHY_IRQ_R14); info.spsr = 8'(PHY_IRQ_SPSR);
    end else if (exc[2]) begin
      info.mode = ABT_MODE; info.vector = VEC_IABT;
      info.r14 = 8'(PHY_ABT_R14); info.spsr = 8'(PHY_ABT_SPSR);
    end else if (exc[1]) begin
      info.mode = SVC_MODE; info.vector = VEC_SWI;
      info.r14 = 8'(PHY_SVC_R14); info.spsr = 8'(PHY_SVC_SPSR);
    end else begin
      info.mode = UND_MODE; info.vector = VEC_UND;
      info.r14 = 8'(PHY_UND_R14); info.spsr = 8'(PHY_UND_SPSR);
    end
    return info;
  endfunction

endpackage

// File: rtl/zap_regf_storage.sv
// rtl/zap_regf_storage.sv - register flop array with bypassed read ports
// Purpose: PHY_REGS x DATA_W flop array, WR_PORTS write ports, NUM_RD
//          combinational read ports with same-cycle write-to-read bypass.
// Ports:   clk; wr_en/wr_index/wr_data (packed per write port);
//          rd_index (packed) -> rd_data (packed, combinational).
module zap_regf_storage
  import zap_register_file_gen2_pkg::*;
#(
  parameter int PHY_REGS = 46,
  parameter int IDX_W    = 6,
  parameter int NUM_RD   = 4,
  parameter int WR_PORTS = 2,
  parameter int DATA_W   = 32
) (
  input  logic                       clk,
  input  logic [WR_PORTS-1:0]        wr_en,
  input  logic [WR_PORTS*IDX_W-1:0]  wr_index,
  input  logic [WR_PORTS*DATA_W-1:0] wr_data,
  input  logic [NUM_RD*IDX_W-1:0]    rd_index,
  output logic [NUM_RD*DATA_W-1:0]   rd_data
);

  localparam logic [IDX_W-1:0] RAZ_IDX = IDX_W'(PHY_RAZ_REGISTER);

  logic [DATA_W-1:0] mem [PHY_REGS];

  // Higher-numbered ports are applied last, so port 1 wins a collision.
  always_ff @(posedge clk) begin
    for (int p = 0; p < WR_PORTS; p++) begin
      if (wr_en[p] && wr_index[p*IDX_W +: IDX_W] != RAZ_IDX)
        mem[wr_index[p*IDX_W +: IDX_W]] <= wr_data[p*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    rd_data = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      rd_data[r*DATA_W +: DATA_W] = mem[rd_index[r*IDX_W +: IDX_W]];
      for (int p = 0; p < WR_PORTS; p++) begin
        if (wr_en[p] && wr_index[p*IDX_W +: IDX_W] == rd_index[r*IDX_W +: IDX_W])
          rd_data[r*DATA_W +: DATA_W] = wr_data[p*DATA_W +: DATA_W];
      end
      if (rd_index[r*IDX_W +: IDX_W] == RAZ_IDX)
        rd_data[r*DATA_W +: DATA_W] = '0;
    end
  end

endmodule

// File: rtl/zap_register_file_gen2.sv
// rtl/zap_register_file_gen2.sv - ZAP register file with PC/CPSR and exception entry
// Purpose: owns register array, PC and CPSR; computes next PC from exception,
//          PC write, clear and stall; sequences exception entry (R14 + SPSR).
// Ports:   i_clk, i_reset (sync, active-high); writeback controls i_valid,
//          i_stall, i_clear/i_clear_pc, i_exc/i_exc_lr, i_flags; register
//          ports i_rd_index/o_rd_data, i_wr_en/i_wr_index/i_wr_data; status
//          o_pc, o_pc_nxt, o_cpsr, o_clear, o_fiq_ack, o_irq_ack, o_busy.
module zap_register_file_gen2
  import zap_register_file_gen2_pkg::*;
#(
  parameter  int PHY_REGS = 46,
  parameter  int NUM_RD   = 4,
  parameter  int WR_PORTS = 2,
  parameter  int DATA_W   = 32,
  localparam int IDX_W    = $clog2(PHY_REGS)
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_valid,
  input  logic                       i_stall,
  input  logic                       i_clear,
  input  logic [31:0]                i_clear_pc,
  input  logic [5:0]                 i_exc,
  input  logic [31:0]                i_exc_lr,
  input  logic [NUM_RD*IDX_W-1:0]    i_rd_index,
  output logic [NUM_RD*DATA_W-1:0]   o_rd_data,
  input  logic [WR_PORTS-1:0]        i_wr_en,
  input  logic [WR_PORTS*IDX_W-1:0]  i_wr_index,
  input  logic [WR_PORTS*DATA_W-1:0] i_wr_data,
  input  logic [31:0]                i_flags,
  output logic [31:0]                o_pc,
  output logic [31:0]                o_pc_nxt,
  output logic [31:0]                o_cpsr,
  output logic                       o_clear,
  output logic                       o_fiq_ack,
  output logic                       o_irq_ack,
  output logic                       o_busy
);

  localparam logic [IDX_W-1:0] PC_IDX   = IDX_W'(ARCH_PC);
  localparam logic [IDX_W-1:0] CPSR_IDX = IDX_W'(PHY_CPSR);

  regf_state_t state, state_nxt;
  logic [31:0] pc, pc_nxt, cpsr, cpsr_nxt, saved_cpsr;
  logic [IDX_W-1:0] saved_spsr_idx;
  exc_info_t exc;
  logic exc_take, commit;
  logic pc_wr, cpsr_wr;
  logic [31:0] pc_wr_data, cpsr_wr_data;
  logic [WR_PORTS-1:0]        st_wr_en;
  logic [WR_PORTS*IDX_W-1:0]  st_wr_index;
  logic [WR_PORTS*DATA_W-1:0] st_wr_data;
  logic [NUM_RD*DATA_W-1:0]   st_rd_data;

  assign exc      = exc_decode(i_exc);
  // Exceptions are only arbitrated from IDLE; a valid instruction commits
  // only when no exception is being taken in the same cycle.
  assign exc_take = !i_reset && state == IDLE && (|i_exc);
  assign commit   = !i_reset && state == IDLE && !(|i_exc) && i_valid;

  always_comb begin
    pc_wr = 1'b0; pc_wr_data = '0;
    cpsr_wr = 1'b0; cpsr_wr_data = '0;
    for (int p = 0; p < WR_PORTS; p++) begin
      if (commit && i_wr_en[p] && i_wr_index[p*IDX_W +: IDX_W] == PC_IDX) begin
        pc_wr = 1'b1; pc_wr_data = i_wr_data[p*DATA_W +: 32];
      end
      if (commit && i_wr_en[p] && i_wr_index[p*IDX_W +: IDX_W] == CPSR_IDX) begin
        cpsr_wr = 1'b1; cpsr_wr_data = i_wr_data[p*DATA_W +: 32];
      end
    end
  end

  // Storage write-port steering: exception entry, deferred SPSR save, or writeback.
  always_comb begin
    st_wr_en = '0; st_wr_index = '0; st_wr_data = '0;
    if (exc_take) begin
      st_wr_en[0] = 1'b1;
      st_wr_index[0 +: IDX_W] = IDX_W'(exc.r14);
      st_wr_data[0 +: DATA_W] = DATA_W'(i_exc_lr);
      if (WR_PORTS == 2) begin
        st_wr_en[WR_PORTS-1] = 1'b1;
        st_wr_index[(WR_PORTS-1)*IDX_W +: IDX_W] = IDX_W'(exc.spsr);
        st_wr_data[(WR_PORTS-1)*DATA_W +: DATA_W] = DATA_W'(cpsr);
      end
    end else if (state == SAVE_SPSR && !i_reset) begin
      st_wr_en[0] = 1'b1;
      st_wr_index[0 +: IDX_W] = saved_spsr_idx;
      st_wr_data[0 +: DATA_W] = DATA_W'(saved_cpsr);
    end else if (commit) begin
      st_wr_en = i_wr_en; st_wr_index = i_wr_index; st_wr_data = i_wr_data;
    end
  end

  zap_regf_storage #(
    .PHY_REGS(PHY_REGS), .IDX_W(IDX_W), .NUM_RD(NUM_RD),
    .WR_PORTS(WR_PORTS), .DATA_W(DATA_W)
  ) u_storage (
    .clk(i_clk), .wr_en(st_wr_en), .wr_index(st_wr_index), .wr_data(st_wr_data),
    .rd_index(i_rd_index), .rd_data(st_rd_data)
  );

  always_comb begin
    o_rd_data = st_rd_data;
    for (int r = 0; r < NUM_RD; r++) begin
      if (i_rd_index[r*IDX_W +: IDX_W] == PC_IDX)
        o_rd_data[r*DATA_W +: DATA_W] = DATA_W'(pc);
    end
  end

  always_comb begin
    if (exc_take)                pc_nxt = exc.vector;
    else if (state == SAVE_SPSR) pc_nxt = pc;
    else if (pc_wr)              pc_nxt = pc_wr_data;
    else if (i_clear)            pc_nxt = i_clear_pc;
    else if (i_stall)            pc_nxt = pc;
    else                         pc_nxt = pc + (cpsr[CPSR_T] ? 32'd2 : 32'd4);
    pc_nxt[0] = 1'b0;
  end

  always_comb begin
    cpsr_nxt = cpsr;
    if (exc_take) begin
      cpsr_nxt[4:0]   = exc.mode;
      cpsr_nxt[CPSR_I] = 1'b1;
      cpsr_nxt[CPSR_T] = 1'b0;
      if (exc.fiq) cpsr_nxt[CPSR_F] = 1'b1;
    end else if (commit) begin
      cpsr_nxt = cpsr_wr ? cpsr_wr_data : i_flags;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc   <= '0;
      cpsr <= CPSR_RESET;
    end else begin
      pc   <= pc_nxt;
      cpsr <= cpsr_nxt;
    end
    if (exc_take) begin
      saved_cpsr     <= cpsr;
      saved_spsr_idx <= IDX_W'(exc.spsr);
    end
  end

  // FSM: state register
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  // FSM: next state. SAVE_SPSR is only needed when a second write port is absent.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (exc_take && WR_PORTS == 1) state_nxt = SAVE_SPSR;
      SAVE_SPSR: state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    o_busy    = (state == SAVE_SPSR);
    o_clear   = exc_take || pc_wr;
    o_fiq_ack = exc_take && exc.fiq;
    o_irq_ack = exc_take && exc.irq;
  end

  assign o_pc     = pc;
  assign o_pc_nxt = pc_nxt;
  assign o_cpsr   = cpsr;

endmodule

// File: tb/tb_zap_register_file_gen2.sv
// tb/tb_zap_register_file_gen2.sv - scoreboard bench for dual- and single-write-port register files
module tb_zap_register_file_gen2;
  import zap_register_file_gen2_pkg::*;

  localparam int NUM_RD = 4;
  localparam int NREG   = 46;

  typedef struct packed {
    logic [NUM_RD*32-1:0] rd;
    logic [NUM_RD-1:0]    rd_chk;
    logic [31:0]          pc;
    logic [31:0]          pc_nxt;
    logic [31:0]          cpsr;
    logic                 chk_nxt;
    logic                 clr;
    logic                 fiq;
    logic                 irq;
    logic                 busy;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, valid, stall, clear;
  logic [31:0] clear_pc, exc_lr, flags;
  logic [5:0]  exc;
  logic [NUM_RD*6-1:0] rd_index;
  logic [1:0]  wr_en;
  logic [11:0] wr_index;
  logic [63:0] wr_data;

  logic [NUM_RD*32-1:0] rd_a, rd_b;
  logic [31:0] pc_a, pcn_a, cpsr_a, pc_b, pcn_b, cpsr_b;
  logic clr_a, fiq_a, irq_a, busy_a, clr_b, fiq_b, irq_b, busy_b;

  zap_register_file_gen2 #(.PHY_REGS(NREG), .NUM_RD(NUM_RD), .WR_PORTS(2), .DATA_W(32)) dut_a (
    .i_clk(clk), .i_reset(reset), .i_valid(valid), .i_stall(stall), .i_clear(clear),
    .i_clear_pc(clear_pc), .i_exc(exc), .i_exc_lr(exc_lr), .i_rd_index(rd_index),
    .o_rd_data(rd_a), .i_wr_en(wr_en), .i_wr_index(wr_index), .i_wr_data(wr_data),
    .i_flags(flags), .o_pc(pc_a), .o_pc_nxt(pcn_a), .o_cpsr(cpsr_a), .o_clear(clr_a),
    .o_fiq_ack(fiq_a), .o_irq_ack(irq_a), .o_busy(busy_a));

  zap_register_file_gen2 #(.PHY_REGS(NREG), .NUM_RD(NUM_RD), .WR_PORTS(1), .DATA_W(32)) dut_b (
    .i_clk(clk), .i_reset(reset), .i_valid(valid), .i_stall(stall), .i_clear(clear),
    .i_clear_pc(clear_pc), .i_exc(exc), .i_exc_lr(exc_lr), .i_rd_index(rd_index),
    .o_rd_data(rd_b), .i_wr_en(wr_en[0:0]), .i_wr_index(wr_index[5:0]), .i_wr_data(wr_data[31:0]),
    .i_flags(flags), .o_pc(pc_b), .o_pc_nxt(pcn_b), .o_cpsr(cpsr_b), .o_clear(clr_b),
    .o_fiq_ack(fiq_b), .o_irq_ack(irq_b), .o_busy(busy_b));

  // Reference model state, [0] = two write ports, [1] = one write port.
  logic [31:0] m_mem   [2][NREG];
  bit          m_known [2][NREG];
  logic [31:0] m_pc [2], m_cpsr [2], m_sv_cpsr [2];
  int          m_sv_idx [2];
  bit          m_save [2];

  // Exception table indexed by request bit {und, swi, iabt, irq, fiq, dabt}.
  logic [4:0]  t_mode [6];
  logic [31:0] t_vec  [6];
  int          t_r14 [6], t_spsr [6];

  exp_t qa [$], qb [$];
  int checks = 0, errors = 0;

  task automatic step(input int k, output exp_t e);
    int wp, nw, b, ridx;
    int widx [2];
    logic [31:0] wdat [2];
    logic [31:0] pc_n, cpsr_n, v;
    bit save_n, pcw, cpsrw, kn;
    logic [31:0] pcd, cpsrd;
    wp = (k == 0) ? 2 : 1;
    nw = 0; e = '0; widx[0] = 0; widx[1] = 0; wdat[0] = 0; wdat[1] = 0;
    e.pc = m_pc[k]; e.cpsr = m_cpsr[k]; e.busy = m_save[k]; e.chk_nxt = !reset;
    pc_n = m_pc[k]; cpsr_n = m_cpsr[k]; save_n = 0;
    if (reset) begin
      pc_n = 0; cpsr_n = 32'h0000_00D3;
    end else if (m_save[k]) begin
      widx[0] = m_sv_idx[k]; wdat[0] = m_sv_cpsr[k]; nw = 1;
    end else if (exc != 0) begin
      b = 5;
      while (!exc[b]) b--;
      widx[0] = t_r14[b]; wdat[0] = exc_lr; nw = 1;
      if (wp == 2) begin
        widx[1] = t_spsr[b]; wdat[1] = m_cpsr[k]; nw = 2;
      end else begin
        save_n = 1; m_sv_cpsr[k] = m_cpsr[k]; m_sv_idx[k] = t_spsr[b];
      end
      pc_n = t_vec[b];
      cpsr_n[4:0] = t_mode[b]; cpsr_n[7] = 1'b1; cpsr_n[5] = 1'b0;
      if (b == 4) cpsr_n[6] = 1'b1;
      e.clr = 1; e.fiq = (b == 4); e.irq = (b == 3);
    end else begin
      pcw = 0; cpsrw = 0; pcd = 0; cpsrd = 0;
      if (valid) begin
        for (int p = 0; p < wp; p++) begin
          if (wr_en[p]) begin
            widx[nw] = int'(wr_index[p*6 +: 6]); wdat[nw] = wr_data[p*32 +: 32];
            if (widx[nw] == ARCH_PC) begin pcw = 1; pcd = wdat[nw]; end
            if (widx[nw] == PHY_CPSR) begin cpsrw = 1; cpsrd = wdat[nw]; end
            nw++;
          end
        end
        cpsr_n = cpsrw ? cpsrd : flags;
      end
      if (pcw) begin pc_n = pcd; e.clr = 1; end
      else if (clear) pc_n = clear_pc;
      else if (!stall) pc_n = m_pc[k] + (m_cpsr[k][5] ? 32'd2 : 32'd4);
      pc_n[0] = 1'b0;
    end
    e.pc_nxt = pc_n;
    for (int r = 0; r < NUM_RD; r++) begin
      ridx = int'(rd_index[r*6 +: 6]);
      kn = 1; v = 0;
      if (ridx == ARCH_PC) v = m_pc[k];
      else if (ridx != PHY_RAZ_REGISTER) begin
        kn = m_known[k][ridx]; v = m_mem[k][ridx];
        for (int w = 0; w < nw; w++)
          if (widx[w] == ridx) begin v = wdat[w]; kn = 1; end
      end
      e.rd[r*32 +: 32] = v; e.rd_chk[r] = kn;
    end
    for (int w = 0; w < nw; w++)
      if (widx[w] != PHY_RAZ_REGISTER) begin
        m_mem[k][widx[w]] = wdat[w]; m_known[k][widx[w]] = 1;
      end
    m_pc[k] = pc_n; m_cpsr[k] = cpsr_n; m_save[k] = save_n;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic compare(input string id, input exp_t e, input logic [NUM_RD*32-1:0] rd,
                         input logic [31:0] pc, input logic [31:0] pcn, input logic [31:0] cpsr,
                         input logic clr, input logic fiq, input logic irq, input logic busy);
    for (int r = 0; r < NUM_RD; r++)
      if (e.rd_chk[r]) chk($sformatf("%s rd%0d", id, r), rd[r*32 +: 32], e.rd[r*32 +: 32]);
    chk({id, " pc"}, pc, e.pc);
    chk({id, " cpsr"}, cpsr, e.cpsr);
    if (e.chk_nxt) chk({id, " pc_nxt"}, pcn, e.pc_nxt);
    chk({id, " clear"}, 32'(clr), 32'(e.clr));
    chk({id, " fiq_ack"}, 32'(fiq), 32'(e.fiq));
    chk({id, " irq_ack"}, 32'(irq), 32'(e.irq));
    chk({id, " busy"}, 32'(busy), 32'(e.busy));
  endtask

  // Monitor: one expected response per cycle per DUT, sampled mid-cycle.
  initial begin
    exp_t ea, eb;
    forever begin
      @(negedge clk);
      if (qa.size() > 0) begin
        ea = qa.pop_front();
        compare("A", ea, rd_a, pc_a, pcn_a, cpsr_a, clr_a, fiq_a, irq_a, busy_a);
      end
      if (qb.size() > 0) begin
        eb = qb.pop_front();
        compare("B", eb, rd_b, pc_b, pcn_b, cpsr_b, clr_b, fiq_b, irq_b, busy_b);
      end
    end
  end

  task automatic defaults();
    reset = 0; valid = 0; stall = 0; clear = 0; clear_pc = 0; exc = 0; exc_lr = 0;
    flags = 32'h0000_00D3; wr_en = 0; wr_index = 0; wr_data = 0;
    rd_index = {6'd3, 6'(PHY_RAZ_REGISTER), 6'(ARCH_PC), 6'd3};
  endtask

  task automatic tick();
    exp_t ea, eb;
    step(0, ea); step(1, eb);
    qa.push_back(ea); qb.push_back(eb);
    @(posedge clk); #1;
  endtask

  initial begin
    t_mode[0] = 5'h1B; t_vec[0] = 32'h04; t_r14[0] = PHY_UND_R14; t_spsr[0] = PHY_UND_SPSR;
    t_mode[1] = 5'h13; t_vec[1] = 32'h08; t_r14[1] = PHY_SVC_R14; t_spsr[1] = PHY_SVC_SPSR;
    t_mode[2] = 5'h17; t_vec[2] = 32'h0C; t_r14[2] = PHY_ABT_R14; t_spsr[2] = PHY_ABT_SPSR;
    t_mode[3] = 5'h12; t_vec[3] = 32'h18; t_r14[3] = PHY_IRQ_R14; t_spsr[3] = PHY_IRQ_SPSR;
    t_mode[4] = 5'h11; t_vec[4] = 32'h1C; t_r14[4] = PHY_FIQ_R14; t_spsr[4] = PHY_FIQ_SPSR;
    t_mode[5] = 5'h17; t_vec[5] = 32'h10; t_r14[5] = PHY_ABT_R14; t_spsr[5] = PHY_ABT_SPSR;
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 0; m_cpsr[k] = 32'h0000_00D3; m_save[k] = 0; m_sv_cpsr[k] = 0; m_sv_idx[k] = 0;
      for (int i = 0; i < NREG; i++) begin m_known[k][i] = 0; m_mem[k][i] = 0; end
    end
    defaults(); reset = 1;
    @(posedge clk); #1;
    // Reset state, then free-running PC 0, 4, 8, 12.
    defaults(); reset = 1; tick();
    repeat (4) begin defaults(); tick(); end
    // Same-cycle bypass, then dual-port collision on R3.
    defaults(); valid = 1; wr_en = 2'b01; wr_index = {6'd0, 6'd3}; wr_data = {32'h0, 32'hDEADBEEF}; tick();
    defaults(); valid = 1; wr_en = 2'b11; wr_index = {6'd3, 6'd3}; wr_data = {32'h2, 32'h1}; tick();
    defaults(); tick();
    // IRQ entry, then read banked R14/SPSR.
    defaults(); exc = 6'b001000; exc_lr = 32'h104;
    rd_index = {6'(PHY_IRQ_SPSR), 6'(PHY_IRQ_R14), 6'(ARCH_PC), 6'd3}; tick();
    repeat (2) begin
      defaults(); rd_index = {6'(PHY_IRQ_SPSR), 6'(PHY_IRQ_R14), 6'(ARCH_PC), 6'd3}; tick();
    end
    // DABT and FIQ together.
    defaults(); exc = 6'b110000; exc_lr = 32'h200; tick();
    repeat (2) begin defaults(); rd_index = {6'(PHY_ABT_SPSR), 6'(PHY_ABT_R14), 6'(PHY_FIQ_R14), 6'd3}; tick(); end
    // PC write under stall.
    defaults(); valid = 1; stall = 1; wr_en = 2'b01; wr_index = {6'd0, 6'(ARCH_PC)}; wr_data = {32'h0, 32'h2000}; tick();
    defaults(); stall = 1; tick();
    // Reset during SAVE_SPSR must not write the SPSR.
    defaults(); valid = 1; wr_en = 2'b01; wr_index = {6'd0, 6'(PHY_SVC_SPSR)}; wr_data = {32'h0, 32'hCAFE0000}; tick();
    defaults(); exc = 6'b000010; exc_lr = 32'h300; tick();
    defaults(); reset = 1; rd_index = {6'(PHY_SVC_SPSR), 6'(PHY_SVC_R14), 6'(ARCH_PC), 6'd3}; tick();
    repeat (2) begin defaults(); rd_index = {6'(PHY_SVC_SPSR), 6'(PHY_SVC_R14), 6'(ARCH_PC), 6'd3}; tick(); end
    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      defaults();
      reset    = ($urandom_range(0, 299) == 0);
      valid    = ($urandom_range(0, 9) < 7);
      stall    = ($urandom_range(0, 4) == 0);
      clear    = ($urandom_range(0, 9) == 0);
      clear_pc = $urandom;
      exc      = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      exc_lr   = $urandom;
      flags    = $urandom;
      wr_en    = 2'($urandom_range(0, 3));
      wr_index = {6'($urandom_range(0, NREG - 1)), 6'($urandom_range(0, NREG - 1))};
      wr_data  = {$urandom, $urandom};
      for (int r = 0; r < NUM_RD; r++) rd_index[r*6 +: 6] = 6'($urandom_range(0, NREG - 1));
      tick();
    end
    defaults();
    repeat (3) @(posedge clk);
    chk("scoreboard drained", 32'(qa.size() + qb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
